// File: rtl/mem_bridge.sv
// Memory-side bridge for the multicycle core: decodes one request at a time to
// on-chip SRAM, MMIO or an error response, returning exactly one response each.
module mem_bridge #(
  parameter logic [31:0] RAM_BASE   = 32'h8000_0000,
  parameter int          RAM_AW     = 16,
  parameter logic [31:0] IO_BASE    = 32'hA000_0000,
  parameter int          IO_AW      = 12,
  parameter int          RAM_LAT    = 1,
  parameter int          IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_mode,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [RAM_AW-3:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              io_valid,
  output logic              io_wen,
  output logic [3:0]        io_be,
  output logic [31:0]       io_addr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata,
  input  logic              io_ready
);

  localparam int CMAX = (IO_TIMEOUT > RAM_LAT) ? IO_TIMEOUT : RAM_LAT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, RAM_WAIT, IO_REQ, RESP} state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic              req_ready_d, rsp_valid_d, rsp_err_d;
  logic [31:0]       rsp_rdata_d;
  logic              ram_en_d, ram_we_d;
  logic [3:0]        ram_be_d;
  logic [RAM_AW-3:0] ram_addr_d;
  logic [31:0]       ram_wdata_d;
  logic              io_valid_d, io_wen_d;
  logic [3:0]        io_be_d;
  logic [31:0]       io_addr_d, io_wdata_d;

  logic [3:0] be;
  logic       misaligned, ram_hit, io_hit;
  logic       unused_mode_bit;

  // Sign-extension is the core's job, so the signedness bit has no effect here.
  assign unused_mode_bit = req_mode[2];

  assign ram_hit    = (req_addr[31:RAM_AW] == RAM_BASE[31:RAM_AW]);
  assign io_hit     = (req_addr[31:IO_AW] == IO_BASE[31:IO_AW]);
  assign misaligned = ((req_mode[1:0] == 2'b01) && req_addr[0]) ||
                      (req_mode[1] && (req_addr[1:0] != 2'b00));

  always_comb begin
    case (req_mode[1:0])
      2'b00:   be = 4'b0001 << req_addr[1:0];
      2'b01:   be = 4'b0011 << {req_addr[1], 1'b0};
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_be    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      io_valid  <= 1'b0;
      io_wen    <= 1'b0;
      io_be     <= '0;
      io_addr   <= '0;
      io_wdata  <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      ram_en    <= ram_en_d;
      ram_we    <= ram_we_d;
      ram_be    <= ram_be_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
      io_valid  <= io_valid_d;
      io_wen    <= io_wen_d;
      io_be     <= io_be_d;
      io_addr   <= io_addr_d;
      io_wdata  <= io_wdata_d;
    end
  end

  // Next-state logic computes the next value of every registered output.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
    ram_en_d    = 1'b0;
    ram_we_d    = ram_we;
    ram_be_d    = ram_be;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    io_valid_d  = io_valid;
    io_wen_d    = io_wen;
    io_be_d     = io_be;
    io_addr_d   = io_addr;
    io_wdata_d  = io_wdata;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          cnt_d = '0;
          if (misaligned || !(ram_hit || io_hit)) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = RESP;
          end else if (ram_hit) begin
            ram_en_d    = 1'b1;
            ram_we_d    = req_wen;
            ram_be_d    = be;
            ram_addr_d  = req_addr[RAM_AW-1:2];
            ram_wdata_d = req_wdata;
            state_d     = RAM_WAIT;
          end else begin
            io_valid_d = 1'b1;
            io_wen_d   = req_wen;
            io_be_d    = be;
            io_addr_d  = req_addr;
            io_wdata_d = req_wdata;
            state_d    = IO_REQ;
          end
        end
      end
      RAM_WAIT: begin
        if (ram_we) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end else if (cnt == CW'(RAM_LAT)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = ram_rdata;
          state_d     = RESP;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      IO_REQ: begin
        // A completion in the final allowed cycle beats the timeout.
        if (io_ready) begin
          io_valid_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = io_wen ? 32'h0 : io_rdata;
          state_d     = RESP;
        end else if (cnt == CW'(IO_TIMEOUT - 1)) begin
          io_valid_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed self-checking bench for mem_bridge with RAM_LAT=2 and IO_TIMEOUT=8.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_mode;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ram_en, ram_we;
  logic [3:0]  ram_be;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        io_valid, io_wen, io_ready;
  logic [3:0]  io_be;
  logic [31:0] io_addr, io_wdata, io_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] pipe0 = '0;
  logic [31:0] pipe1 = '0;

  mem_bridge #(
    .RAM_LAT    (2),
    .IO_TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_mode  (req_mode),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_be    (ram_be),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .io_valid  (io_valid),
    .io_wen    (io_wen),
    .io_be     (io_be),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .io_ready  (io_ready)
  );

  always #5 clk = ~clk;

  // Two-cycle SRAM: data tagged with the word address, zero when not addressed.
  always @(posedge clk) begin
    pipe0 <= ram_en ? {16'hC0DE, 2'b00, ram_addr} : 32'h0;
    pipe1 <= pipe0;
  end
  assign ram_rdata = pipe1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Presents one request for a single edge and returns in cycle N+1.
  task automatic apply_stimulus(input logic wen, input logic [2:0] mode,
                                input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_wen   = wen;
    req_mode  = mode;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_error_path(input string tag);
    check_output({tag, "_ram_en"}, ram_en, 1'b0);
    check_output({tag, "_io_valid"}, io_valid, 1'b0);
    check_output({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    check_output({tag, "_rsp_err"}, rsp_err, 1'b1);
    check_output({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    next_cycle();
    check_output({tag, "_rsp_drop"}, rsp_valid, 1'b0);
    check_output({tag, "_ready_back"}, req_ready, 1'b1);
  endtask

  initial begin
    int  vcnt;
    int  rcnt;
    bit  got;

    rst       = 1'b0;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_mode  = 3'b000;
    req_addr  = '0;
    req_wdata = '0;
    io_ready  = 1'b0;
    io_rdata  = '0;

    next_cycle();
    check_output("rst_req_ready", req_ready, 1'b1);
    check_output("rst_rsp_valid", rsp_valid, 1'b0);
    check_output("rst_ram_en", ram_en, 1'b0);
    check_output("rst_io_valid", io_valid, 1'b0);
    check_output("rst_rsp_rdata", rsp_rdata, 32'h0);
    rst = 1'b1;
    next_cycle();

    // RAM word store
    apply_stimulus(1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF);
    check_output("sw_ram_en", ram_en, 1'b1);
    check_output("sw_ram_we", ram_we, 1'b1);
    check_output("sw_ram_be", ram_be, 4'b1111);
    check_output("sw_ram_addr", ram_addr, 14'h0004);
    check_output("sw_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    check_output("sw_req_ready", req_ready, 1'b0);
    check_output("sw_rsp_early", rsp_valid, 1'b0);
    next_cycle();
    check_output("sw_ram_en_drop", ram_en, 1'b0);
    check_output("sw_rsp_valid", rsp_valid, 1'b1);
    check_output("sw_rsp_err", rsp_err, 1'b0);
    check_output("sw_rsp_rdata", rsp_rdata, 32'h0);
    next_cycle();
    check_output("sw_rsp_drop", rsp_valid, 1'b0);
    check_output("sw_ready_back", req_ready, 1'b1);

    // RAM byte load from the top lane, RAM_LAT=2
    apply_stimulus(1'b0, 3'b000, 32'h8000_0013, 32'h0);
    check_output("lb_ram_en", ram_en, 1'b1);
    check_output("lb_ram_we", ram_we, 1'b0);
    check_output("lb_ram_be", ram_be, 4'b1000);
    check_output("lb_ram_addr", ram_addr, 14'h0004);
    next_cycle();
    check_output("lb_rsp_n2", rsp_valid, 1'b0);
    next_cycle();
    check_output("lb_rsp_n3", rsp_valid, 1'b0);
    next_cycle();
    check_output("lb_rsp_valid", rsp_valid, 1'b1);
    check_output("lb_rsp_rdata", rsp_rdata, 32'hC0DE_0004);
    check_output("lb_rsp_err", rsp_err, 1'b0);
    next_cycle();
    check_output("lb_rsp_drop", rsp_valid, 1'b0);
    check_output("lb_rdata_held", rsp_rdata, 32'hC0DE_0004);
    check_output("lb_ready_back", req_ready, 1'b1);

    // RAM half load from the upper half
    apply_stimulus(1'b0, 3'b101, 32'h8000_0022, 32'h0);
    check_output("lh_ram_be", ram_be, 4'b1100);
    check_output("lh_ram_addr", ram_addr, 14'h0008);
    next_cycle();
    next_cycle();
    next_cycle();
    check_output("lh_rsp_valid", rsp_valid, 1'b1);
    check_output("lh_rsp_rdata", rsp_rdata, 32'hC0DE_0008);
    next_cycle();

    // Error responses: misaligned and unmapped
    apply_stimulus(1'b0, 3'b001, 32'h8000_0001, 32'h0);
    check_error_path("lh_misaligned");
    apply_stimulus(1'b1, 3'b010, 32'h8000_0002, 32'h1234_5678);
    check_error_path("sw_misaligned");
    apply_stimulus(1'b0, 3'b010, 32'h1000_0000, 32'h0);
    check_error_path("lw_unmapped");
    apply_stimulus(1'b0, 3'b010, 32'h8001_0000, 32'h0);
    check_error_path("lw_past_ram");
    apply_stimulus(1'b0, 3'b000, 32'hA000_1000, 32'h0);
    check_error_path("lb_past_io");

    // MMIO word store completing in the fifth io_valid cycle
    apply_stimulus(1'b1, 3'b010, 32'hA000_0004, 32'h1234_5678);
    check_output("io_sw_valid1", io_valid, 1'b1);
    check_output("io_sw_wen", io_wen, 1'b1);
    check_output("io_sw_be", io_be, 4'b1111);
    check_output("io_sw_addr", io_addr, 32'hA000_0004);
    check_output("io_sw_wdata", io_wdata, 32'h1234_5678);
    check_output("io_sw_ram_en", ram_en, 1'b0);
    for (int i = 2; i <= 5; i++) begin
      next_cycle();
      check_output("io_sw_held", io_valid, 1'b1);
      check_output("io_sw_no_rsp", rsp_valid, 1'b0);
    end
    io_ready = 1'b1;
    io_rdata = 32'h1111_1111;
    next_cycle();
    io_ready = 1'b0;
    check_output("io_sw_drop", io_valid, 1'b0);
    check_output("io_sw_rsp_valid", rsp_valid, 1'b1);
    check_output("io_sw_rsp_err", rsp_err, 1'b0);
    check_output("io_sw_rsp_rdata", rsp_rdata, 32'h0);
    next_cycle();

    // MMIO word load with no completion: times out after 8 io_valid cycles
    io_rdata = 32'h55AA_55AA;
    apply_stimulus(1'b0, 3'b010, 32'hA000_0100, 32'h0);
    vcnt = 0;
    got  = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (io_valid) vcnt++;
      if (rsp_valid) got = 1'b1;
      else next_cycle();
    end
    check_output("io_to_rsp_seen", got, 1'b1);
    check_output("io_to_valid_cycles", vcnt, 32'd8);
    check_output("io_to_rsp_err", rsp_err, 1'b1);
    check_output("io_to_rsp_rdata", rsp_rdata, 32'h0);
    next_cycle();
    check_output("io_to_ready_back", req_ready, 1'b1);

    // MMIO byte load at the top of the region, immediate completion
    apply_stimulus(1'b0, 3'b100, 32'hA000_0FFF, 32'h0);
    check_output("io_lb_valid", io_valid, 1'b1);
    check_output("io_lb_be", io_be, 4'b1000);
    check_output("io_lb_addr", io_addr, 32'hA000_0FFF);
    io_ready = 1'b1;
    io_rdata = 32'hCAFE_F00D;
    next_cycle();
    io_ready = 1'b0;
    check_output("io_lb_drop", io_valid, 1'b0);
    check_output("io_lb_rsp_valid", rsp_valid, 1'b1);
    check_output("io_lb_rsp_err", rsp_err, 1'b0);
    check_output("io_lb_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
    next_cycle();

    // Back-to-back with req_valid held high
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_mode  = 3'b010;
    req_addr  = 32'h8000_0020;
    req_wdata = 32'hA5A5_0001;
    next_cycle();
    check_output("b2b_first_en", ram_en, 1'b1);
    check_output("b2b_first_addr", ram_addr, 14'h0008);
    next_cycle();
    check_output("b2b_first_rsp", rsp_valid, 1'b1);
    check_output("b2b_no_accept_in_wait", ram_en, 1'b0);
    req_addr = 32'h8000_0024;
    next_cycle();
    check_output("b2b_idle_ready", req_ready, 1'b1);
    check_output("b2b_idle_no_rsp", rsp_valid, 1'b0);
    check_output("b2b_idle_no_en", ram_en, 1'b0);
    next_cycle();
    req_valid = 1'b0;
    check_output("b2b_second_en", ram_en, 1'b1);
    check_output("b2b_second_addr", ram_addr, 14'h0009);
    next_cycle();
    check_output("b2b_second_rsp", rsp_valid, 1'b1);
    next_cycle();
    check_output("b2b_ready_back", req_ready, 1'b1);
    next_cycle();
    check_output("b2b_no_third", ram_en, 1'b0);

    // Reset asserted while a RAM read is outstanding
    apply_stimulus(1'b0, 3'b010, 32'h8000_0040, 32'h0);
    check_output("rstmid_ram_en_before", ram_en, 1'b1);
    rst = 1'b0;
    #1;
    check_output("rstmid_ram_en", ram_en, 1'b0);
    check_output("rstmid_io_valid", io_valid, 1'b0);
    check_output("rstmid_rsp_valid", rsp_valid, 1'b0);
    check_output("rstmid_req_ready", req_ready, 1'b1);
    next_cycle();
    rst = 1'b1;
    rcnt = 0;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      if (rsp_valid) rcnt++;
    end
    check_output("rstmid_no_response", rcnt, 32'd0);
    check_output("rstmid_ready_after", req_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
